prng_word_buffer: RTL and testbench
===================================

Name: prng_word_buffer

Overview:
- Downstream consumer of the byte-serial PRNG top.
- Issues single-cycle get_random requests and captures the 4 random bytes that follow, least significant byte first.
- Packs each group of 4 bytes into a 32-bit word and stores it in a small first-word-fall-through FIFO.
- Presents words to the rest of the design with a valid/ready handshake, keeping the FIFO topped up in the background.

Parameters:
- REQ_LAT, 2: cycles from the get_random pulse (cycle 0) to the first valid byte on rnd_byte. Legal range 1..15.
- DEPTH, 4: FIFO depth in 32-bit words. Power of two, 2..16.
- AW, 2: FIFO address width; equals log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  refill enable; new requests are issued only while high.
- rnd_byte  in  8  PRNG data_out byte.
- get_random  out  1  one-cycle request pulse to the PRNG.
- word_data  out  32  FIFO head word; only meaningful while word_valid=1.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts the head word this cycle.
- level  out  AW+1  number of words currently stored.
- busy  out  1  a request/capture transaction is in flight.

Behaviour:
- Reset: async assert clears all state.
  - get_random=0, word_valid=0, word_data=0, level=0, busy=0, FSM=IDLE.
  - Assembly register and FIFO pointers cleared.
  - Outputs are held at reset values until the first clk edge after rst deasserts.
- FSM states: IDLE, REQ, WAIT, CAPTURE.
  - IDLE -> REQ when en=1 and level<DEPTH. Otherwise stay in IDLE.
  - REQ: get_random=1 for exactly this one cycle; busy=1. Next state is WAIT, or CAPTURE directly if REQ_LAT=1.
  - WAIT: a down-counter runs for REQ_LAT-1 cycles, then the FSM moves to CAPTURE.
  - CAPTURE: 4 cycles; byte counter k=0..3.
    - Each cycle, rnd_byte is stored into assembly bits [8k+7:8k].
    - On the edge closing k=3, the assembled word is pushed into the FIFO; next state is IDLE.
  - Minimum 1 IDLE cycle between transactions, so back-to-back request pulses are always at least REQ_LAT+5 cycles apart.
- Only one transaction is in flight at a time.
  - Space is checked at request time and only this block pushes, so a push never finds the FIFO full.
- en deasserted mid-transaction: the transaction completes and its word is pushed; no further requests are issued.
- FIFO behaviour:
  - word_data/word_valid reflect the head with zero latency (first-word fall-through).
  - Pop happens on a clk edge where word_valid & word_ready.
  - Pop when empty: ignored; level does not underflow.
  - Push and pop on the same edge: level unchanged; head advances.
  - Push into an empty FIFO: word_valid rises the cycle after the push edge.
  - Pointers wrap modulo DEPTH.
  - level ranges 0..DEPTH.
- word_data is held while word_valid=1 and word_ready=0.

Optional Feature:
- Macro: PRNG_REPEAT_CHECK_EN.
- When defined:
  - Each assembled word is compared with the previously assembled word; reset value of that register is 0.
  - On a match, the word is not pushed and sticky output repeat_err (1 bit, reset 0) is set. It clears only on rst.
  - The FSM continues normally, and the next request follows the usual IDLE rules.
  - An all-zero first word after reset also counts as a repeat.
- When not defined: the repeat_err port and comparison logic are absent; every assembled word is pushed.

Test Plan:
- Request timing: REQ_LAT=2, en=1, word_ready=0; model drives bytes 0x11,0x22,0x33,0x44 on cycles 2..5 after the pulse.
  - -> word_data=0x44332211; word_valid=1 from cycle 7; level=1.
- Fill to full: en=1, word_ready=0.
  - -> exactly 4 get_random pulses, each spaced 7 cycles; level=4; no 5th pulse while full.
- Pop frees a slot: after full, pulse word_ready=1 for 1 cycle.
  - -> level=3; a new pulse within 2 cycles; level returns to 4 after the capture.
- Simultaneous push and pop: level=2, word_ready=1 held across a push edge.
  - -> level stays 2 on that edge; head advances in order, no word lost or duplicated.
- Disable and reset mid-flight:
  - en drops during WAIT -> the word is still pushed and no further pulses.
  - rst asserted during CAPTURE k=2 -> level=0, get_random=0 and word_valid=0 immediately; no partial word appears after release.
- PRNG_REPEAT_CHECK_EN: two consecutive transactions both return 0xDEADBEEF.
  - -> only the first is stored; repeat_err=1; level=1.

Source files
------------

// File: rtl/prng_word_buffer.sv
// prng_word_buffer: pulls 4-byte groups from the byte-serial PRNG, packs them LSB-first into
// 32-bit words and serves them from a first-word-fall-through FIFO. Optional: PRNG_REPEAT_CHECK_EN.
module prng_word_buffer #(
  parameter int REQ_LAT = 2,
  parameter int DEPTH   = 4,
  parameter int AW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    rnd_byte,
  output logic          get_random,
  output logic [31:0]   word_data,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [AW:0]   level,
  output logic          busy
`ifdef PRNG_REPEAT_CHECK_EN
  ,
  output logic          repeat_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (REQ_LAT > 1) ? 4'(REQ_LAT - 2) : 4'd0;

  state_t        state;
  state_t        next_state;
  logic [3:0]    wait_cnt;
  logic [1:0]    byte_cnt;
  logic [31:0]   assembly;
  logic          push_pend;
  logic          cap_last;
  logic [31:0]   full_word;
  logic          store_word;
  logic [AW+1:0] committed;
  logic          has_space;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   level_nxt;
  logic [31:0]   head_nxt;
  logic          do_pop;
  logic          do_push;

  // A word waiting in push_pend already owns a slot, so it counts against free space.
  always_comb begin
    committed = (AW+2)'(level) + (AW+2)'(push_pend);
    has_space = (committed < (AW+2)'(DEPTH));
    cap_last  = (state == ST_CAPTURE) && (byte_cnt == 2'd3);
    full_word = {rnd_byte, assembly[23:0]};
  end

  // Next-state logic for the request/capture sequencer
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (en && has_space) next_state = ST_REQ;
        else                 next_state = ST_IDLE;
      end
      ST_REQ: begin
        if (REQ_LAT == 1) next_state = ST_CAPTURE;
        else              next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) next_state = ST_CAPTURE;
        else                  next_state = ST_WAIT;
      end
      ST_CAPTURE: begin
        if (byte_cnt == 2'd3) next_state = ST_IDLE;
        else                  next_state = ST_CAPTURE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

`ifdef PRNG_REPEAT_CHECK_EN
  logic [31:0] prev_word;

  always_comb begin
    store_word = cap_last && (full_word != prev_word);
  end

  // Remember the last assembled word and flag a sticky error when it repeats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_word  <= 32'd0;
      repeat_err <= 1'b0;
    end else begin
      if (cap_last) begin
        prev_word <= full_word;
        if (full_word == prev_word) repeat_err <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    store_word = cap_last;
  end
`endif

  // Sequencer state, registered request/busy outputs and byte assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      get_random <= 1'b0;
      busy       <= 1'b0;
      wait_cnt   <= 4'd0;
      byte_cnt   <= 2'd0;
      assembly   <= 32'd0;
      push_pend  <= 1'b0;
    end else begin
      state      <= next_state;
      get_random <= (next_state == ST_REQ);
      busy       <= (next_state != ST_IDLE);
      push_pend  <= store_word;
      if (state == ST_REQ) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == ST_CAPTURE) begin
        assembly[8*byte_cnt +: 8] <= rnd_byte;
        byte_cnt                  <= byte_cnt + 2'd1;
      end
    end
  end

  // The completed word enters the FIFO one edge after capture; bypass covers an empty FIFO.
  always_comb begin
    do_pop     = word_valid && word_ready;
    do_push    = push_pend;
    rd_ptr_nxt = do_pop ? (rd_ptr + AW'(1)) : rd_ptr;
    level_nxt  = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push && (wr_ptr == rd_ptr_nxt)) head_nxt = assembly;
    else                                   head_nxt = mem[rd_ptr_nxt];
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= assembly;
  end

  // FIFO pointers and registered head/level view
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      level      <= {(AW+1){1'b0}};
      word_valid <= 1'b0;
      word_data  <= 32'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_nxt;
      level      <= level_nxt;
      word_valid <= (level_nxt != {(AW+1){1'b0}});
      if (level_nxt != {(AW+1){1'b0}}) word_data <= head_nxt;
    end
  end

endmodule

// File: tb/tb_prng_word_buffer.sv
// tb_prng_word_buffer: directed + random stimulus for prng_word_buffer against a
// queue-based reference of request windows, visible words and pops.
module tb_prng_word_buffer;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          word_ready;
  logic [7:0]    rnd_byte;
  logic          get_random;
  logic [31:0]   word_data;
  logic          word_valid;
  logic [AW:0]   level;
  logic          busy;
`ifdef PRNG_REPEAT_CHECK_EN
  logic          repeat_err;
`endif

  prng_word_buffer #(.REQ_LAT(L), .DEPTH(D), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .rnd_byte(rnd_byte), .get_random(get_random),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .level(level), .busy(busy)
`ifdef PRNG_REPEAT_CHECK_EN
    , .repeat_err(repeat_err)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_w[$];
  int          pend_r[$];
  int          pulse_t[$];
  bit          cap_active;
  int          cap_start;
  logic [31:0] cap_word;
  int          last_pulse;
  int          occ_prev;
  bit          valid_prev;
  bit          use_dir;
  logic [31:0] dir_word;
  logic [31:0] prev_word;
  bit          rep_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_w.delete();
    pend_r.delete();
    cap_active = 1'b0;
    cap_start  = 0;
    cap_word   = 32'd0;
    last_pulse = -1;
    occ_prev   = 0;
    valid_prev = 1'b0;
    prev_word  = 32'd0;
    rep_exp    = 1'b0;
  endtask

  // One clock: sample cycle cyc, update the reference, then drive rnd_byte for that cycle.
  task automatic step();
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    if (valid_prev && word_ready) void'(exp_q.pop_front());
    while (pend_r.size() > 0 && pend_r[0] == cyc) begin
      exp_q.push_back(pend_w.pop_front());
      void'(pend_r.pop_front());
    end
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("word_valid", 32'(word_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("word_data", word_data, exp_q[0]);
    if (get_random) begin
      if (last_pulse >= 0) chk("pulse_spacing", 32'((cyc - last_pulse) >= (L + 5)), 32'd1);
      chk("pulse_allowed", 32'(en && (occ_prev < D) && !cap_active), 32'd1);
      last_pulse = cyc;
      pulse_t.push_back(cyc);
      cap_active = 1'b1;
      cap_start  = cyc + L;
      cap_word   = 32'd0;
    end
`ifdef PRNG_REPEAT_CHECK_EN
    chk("repeat_err", 32'(repeat_err), 32'(rep_exp));
`endif
    valid_prev = (exp_q.size() != 0);
    if (cap_active && cyc >= cap_start) begin
      idx = cyc - cap_start;
      rnd_byte = use_dir ? dir_word[8*idx +: 8] : 8'($urandom);
      cap_word[8*idx +: 8] = rnd_byte;
      if (idx == 3) begin
        cap_active = 1'b0;
`ifdef PRNG_REPEAT_CHECK_EN
        if (cap_word == prev_word) rep_exp = 1'b1;
        else begin
          pend_w.push_back(cap_word);
          pend_r.push_back(cap_start + 5);
        end
        prev_word = cap_word;
`else
        pend_w.push_back(cap_word);
        pend_r.push_back(cap_start + 5);
`endif
      end
    end else begin
      rnd_byte = 8'($urandom);
    end
    occ_prev = exp_q.size() + pend_w.size() + int'(cap_active);
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_pulse(output int p, input int max_cycles);
    bit found;
    found = 1'b0;
    p = cyc;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (get_random) begin
        found = 1'b1;
        p = cyc;
        break;
      end
    end
    chk("pulse_timeout", 32'(found), 32'd1);
  endtask

  initial begin
    int p;
    int n0;
    rst = 1'b1; en = 1'b0; word_ready = 1'b0; rnd_byte = 8'h00;
    use_dir = 1'b0; dir_word = 32'd0;
    model_clear();
    #1;
    chk("rst_get_random", 32'(get_random), 32'd0);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_data", word_data, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) step();
    rst = 1'b0;

    // request timing with fixed bytes
    use_dir = 1'b1; dir_word = 32'h44332211; en = 1'b1; pulse_t.delete();
    wait_pulse(p, 10);
    step_to(p + 6);
    chk("t1_valid_c6", 32'(word_valid), 32'd0);
    step();
    chk("t1_valid_c7", 32'(word_valid), 32'd1);
    chk("t1_data", word_data, 32'h44332211);
    chk("t1_level", 32'(level), 32'd1);
    use_dir = 1'b0;

    // fill to full
    step_to(p + 45);
    chk("t2_pulses", 32'(pulse_t.size()), 32'd4);
    for (int i = 1; i < pulse_t.size(); i++)
      chk("t2_spacing", 32'(pulse_t[i] - pulse_t[i-1]), 32'(L + 5));
    chk("t2_level", 32'(level), 32'd4);

    // single pop frees a slot
    pulse_t.delete();
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    chk("t3_level", 32'(level), 32'd3);
    step(); step();
    chk("t3_pulse", 32'(pulse_t.size()), 32'd1);
    step_to(cyc + 12);
    chk("t3_refill", 32'(level), 32'd4);

    // simultaneous push and pop at level 2
    en = 1'b0; word_ready = 1'b1;
    step(); step();
    word_ready = 1'b0;
    chk("t4_level2", 32'(level), 32'd2);
    en = 1'b1;
    wait_pulse(p, 5);
    step_to(p + 6);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    chk("t4_level_pushpop", 32'(level), 32'd2);

    // en dropped during WAIT
    en = 1'b0; word_ready = 1'b1;
    repeat (40) step();
    word_ready = 1'b0;
    chk("t5_drained", 32'(level), 32'd0);
    en = 1'b1; pulse_t.delete();
    wait_pulse(p, 5);
    step();
    en = 1'b0;
    step_to(p + 7);
    chk("t5_pushed", 32'(level), 32'd1);
    n0 = pulse_t.size();
    repeat (30) step();
    chk("t5_no_pulse", 32'(pulse_t.size()), 32'(n0));
    chk("t5_level", 32'(level), 32'd1);

    // reset during CAPTURE k=2
    en = 1'b1;
    wait_pulse(p, 10);
    step_to(p + L + 2);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_get_random", 32'(get_random), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_word_valid", 32'(word_valid), 32'd0);
    model_clear();
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();
    chk("t6_no_partial", 32'(level), 32'd0);
    chk("t6_no_valid", 32'(word_valid), 32'd0);

    // random traffic
    repeat (600) begin
      en = ($urandom_range(0, 3) != 0);
      word_ready = ($urandom_range(0, 2) == 0);
      step();
    end

`ifdef PRNG_REPEAT_CHECK_EN
    // repeated word is dropped and flagged
    en = 1'b0; word_ready = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    repeat (2) step();
    rst = 1'b0;
    chk("t8_err_clear", 32'(repeat_err), 32'd0);
    use_dir = 1'b1; dir_word = 32'hDEADBEEF; en = 1'b1;
    wait_pulse(p, 10);
    wait_pulse(p, 15);
    en = 1'b0;
    repeat (20) step();
    chk("t8_level", 32'(level), 32'd1);
    chk("t8_repeat_err", 32'(repeat_err), 32'd1);
    chk("t8_data", word_data, 32'hDEADBEEF);
    use_dir = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
